// File: rtl/branch_seq.sv
// branch_seq: control sequencer for a conditional-branch instruction.
// Walks IDLE -> EVAL -> PCY -> (ADDR -> WB ->) FIN. The branch is taken only
// when CON is high in PCY; only a taken branch reaches ADDR/WB and loads the PC.
// Ports:
//   clock, clear (async active-low reset), start, ir[31:0], con   - inputs
//   Gra, Rout, CONin, ra_sel[3:0]                                 - EVAL strobes
//   PCout, Yin, Cout, op_add, Zin, Zlowout, PCin, c_sext[31:0]    - datapath strobes
//   busy, done, taken, bad_op                                     - status
//   taken_cnt, ntaken_cnt [CNT_W-1:0]                             - saturating outcome counters
// Every output is a flop loaded from a decode of the next state, so each
// strobe is high during exactly the cycle the FSM spends in that state.
module branch_seq #(
  parameter logic [4:0] BR_OPCODE = 5'b10010,
  parameter int         CNT_W     = 16
) (
  input  logic             clock,
  input  logic             clear,
  input  logic             start,
  input  logic [31:0]      ir,
  input  logic             con,
  output logic             Gra,
  output logic             Rout,
  output logic             CONin,
  output logic [3:0]       ra_sel,
  output logic             PCout,
  output logic             Yin,
  output logic             Cout,
  output logic             op_add,
  output logic             Zin,
  output logic             Zlowout,
  output logic             PCin,
  output logic [31:0]      c_sext,
  output logic             busy,
  output logic             done,
  output logic             taken,
  output logic             bad_op,
  output logic [CNT_W-1:0] taken_cnt,
  output logic [CNT_W-1:0] ntaken_cnt
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_EVAL = 3'd1,
    S_PCY  = 3'd2,
    S_ADDR = 3'd3,
    S_WB   = 3'd4,
    S_FIN  = 3'd5
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  state_t             state_q, state_d;
  logic [31:0]        ir_q, ir_d;
  logic               taken_q, taken_d;
  logic [CNT_W-1:0]   tcnt_q, tcnt_d, ncnt_q, ncnt_d;

  logic gra_q, gra_d, rout_q, rout_d, conin_q, conin_d;
  logic pcout_q, pcout_d, yin_q, yin_d, cout_q, cout_d, add_q, add_d;
  logic zin_q, zin_d, zlow_q, zlow_d, pcin_q, pcin_d;
  logic busy_q, busy_d, done_q, done_d, tko_q, tko_d, bad_q, bad_d;
  logic [3:0]  ra_q, ra_d;
  logic [31:0] cs_q, cs_d;

  // Opcode and condition-code fields are held but not needed by this sequencer.
  logic ir_unused_s;
  assign ir_unused_s = ^{ir_q[31:27], ir_q[22:19]};

  // Next-state, instruction capture, branch outcome and counter updates.
  always_comb begin
    state_d = state_q;
    ir_d    = ir_q;
    taken_d = taken_q;
    tcnt_d  = tcnt_q;
    ncnt_d  = ncnt_q;
    bad_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (ir[31:27] == BR_OPCODE) begin
            state_d = S_EVAL;
            ir_d    = ir;
          end else begin
            bad_d = 1'b1;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_EVAL: state_d = S_PCY;
      S_PCY: begin
        taken_d = con;
        state_d = con ? S_ADDR : S_FIN;
      end
      S_ADDR: state_d = S_WB;
      S_WB:   state_d = S_FIN;
      S_FIN: begin
        state_d = S_IDLE;
        if (taken_q) begin
          tcnt_d = (tcnt_q == CNT_MAX) ? tcnt_q : tcnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
          ncnt_d = (ncnt_q == CNT_MAX) ? ncnt_q : ncnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Strobe decode from the next state so the registered strobes line up with it.
  always_comb begin
    gra_d   = 1'b0; rout_d = 1'b0; conin_d = 1'b0; ra_d  = 4'd0;
    pcout_d = 1'b0; yin_d  = 1'b0; cout_d  = 1'b0; add_d = 1'b0;
    zin_d   = 1'b0; zlow_d = 1'b0; pcin_d  = 1'b0; cs_d  = 32'd0;
    done_d  = 1'b0; tko_d  = 1'b0;
    busy_d  = (state_d != S_IDLE);
    case (state_d)
      S_IDLE: busy_d = 1'b0;
      S_EVAL: begin
        gra_d = 1'b1; rout_d = 1'b1; conin_d = 1'b1;
        ra_d  = ir_d[26:23];
      end
      S_PCY: begin
        pcout_d = 1'b1; yin_d = 1'b1;
      end
      S_ADDR: begin
        cout_d = 1'b1; add_d = 1'b1; zin_d = 1'b1;
        cs_d   = {{13{ir_d[18]}}, ir_d[18:0]};
      end
      S_WB: begin
        zlow_d = 1'b1; pcin_d = 1'b1;
      end
      S_FIN: begin
        done_d = 1'b1;
        tko_d  = taken_d;
      end
      default: busy_d = 1'b0;
    endcase
  end

  // State, captured instruction, outcome, counters and registered outputs.
  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      state_q <= S_IDLE;
      ir_q    <= 32'd0;
      taken_q <= 1'b0;
      tcnt_q  <= {CNT_W{1'b0}};
      ncnt_q  <= {CNT_W{1'b0}};
      gra_q   <= 1'b0; rout_q <= 1'b0; conin_q <= 1'b0; ra_q  <= 4'd0;
      pcout_q <= 1'b0; yin_q  <= 1'b0; cout_q  <= 1'b0; add_q <= 1'b0;
      zin_q   <= 1'b0; zlow_q <= 1'b0; pcin_q  <= 1'b0; cs_q  <= 32'd0;
      busy_q  <= 1'b0; done_q <= 1'b0; tko_q   <= 1'b0; bad_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ir_q    <= ir_d;
      taken_q <= taken_d;
      tcnt_q  <= tcnt_d;
      ncnt_q  <= ncnt_d;
      gra_q   <= gra_d;   rout_q <= rout_d; conin_q <= conin_d; ra_q  <= ra_d;
      pcout_q <= pcout_d; yin_q  <= yin_d;  cout_q  <= cout_d;  add_q <= add_d;
      zin_q   <= zin_d;   zlow_q <= zlow_d; pcin_q  <= pcin_d;  cs_q  <= cs_d;
      busy_q  <= busy_d;  done_q <= done_d; tko_q   <= tko_d;   bad_q <= bad_d;
    end
  end

  assign Gra        = gra_q;
  assign Rout       = rout_q;
  assign CONin      = conin_q;
  assign ra_sel     = ra_q;
  assign PCout      = pcout_q;
  assign Yin        = yin_q;
  assign Cout       = cout_q;
  assign op_add     = add_q;
  assign Zin        = zin_q;
  assign Zlowout    = zlow_q;
  assign PCin       = pcin_q;
  assign c_sext     = cs_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign taken      = tko_q;
  assign bad_op     = bad_q;
  assign taken_cnt  = tcnt_q;
  assign ntaken_cnt = ncnt_q;

endmodule

// File: tb/tb_branch_seq.sv
// Bench for branch_seq: two instances share all stimulus, one with 16-bit and
// one with 2-bit counters. Expected outputs come from a per-cycle phase table
// and counter totals kept by the bench.
module tb_branch_seq;

  localparam logic [4:0] BR = 5'b10010;
  localparam int P_IDLE = 0, P_BAD = 1, P_EVAL = 2, P_PCY = 3, P_ADDR = 4, P_WB = 5, P_FIN = 6;

  logic        clock, clear, start, con;
  logic [31:0] ir;

  logic        gra, rout, conin, pcout, yin, cout, add, zin, zlo, pcin, busy, done, tk, bad;
  logic [3:0]  ra;
  logic [31:0] cs;
  logic [15:0] tcnt, ncnt;
  logic        s_gra, s_rout, s_conin, s_pcout, s_yin, s_cout, s_add, s_zin, s_zlo, s_pcin;
  logic        s_busy, s_done, s_tk, s_bad;
  logic [3:0]  s_ra;
  logic [31:0] s_cs;
  logic [1:0]  s_tcnt, s_ncnt;

  int checks = 0;
  int errors = 0;
  int m_t = 0, m_n = 0;

  branch_seq #(.BR_OPCODE(BR), .CNT_W(16)) u_dut (
    .clock(clock), .clear(clear), .start(start), .ir(ir), .con(con),
    .Gra(gra), .Rout(rout), .CONin(conin), .ra_sel(ra), .PCout(pcout), .Yin(yin),
    .Cout(cout), .op_add(add), .Zin(zin), .Zlowout(zlo), .PCin(pcin), .c_sext(cs),
    .busy(busy), .done(done), .taken(tk), .bad_op(bad),
    .taken_cnt(tcnt), .ntaken_cnt(ncnt)
  );

  branch_seq #(.BR_OPCODE(BR), .CNT_W(2)) u_sat (
    .clock(clock), .clear(clear), .start(start), .ir(ir), .con(con),
    .Gra(s_gra), .Rout(s_rout), .CONin(s_conin), .ra_sel(s_ra), .PCout(s_pcout), .Yin(s_yin),
    .Cout(s_cout), .op_add(s_add), .Zin(s_zin), .Zlowout(s_zlo), .PCin(s_pcin), .c_sext(s_cs),
    .busy(s_busy), .done(s_done), .taken(s_tk), .bad_op(s_bad),
    .taken_cnt(s_tcnt), .ntaken_cnt(s_ncnt)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // Expected strobe vector for one cycle of a given phase.
  function automatic logic [49:0] ev(input int ph, input logic [31:0] irv, input logic tkv);
    logic g, r, c, po, y, co, a, z, zl, pc, b, d, t, bo;
    logic [3:0] rs;
    logic [31:0] sx;
    int v;
    g = 1'b0; r = 1'b0; c = 1'b0; po = 1'b0; y = 1'b0; co = 1'b0; a = 1'b0;
    z = 1'b0; zl = 1'b0; pc = 1'b0; b = 1'b0; d = 1'b0; t = 1'b0; bo = 1'b0;
    rs = 4'd0; sx = 32'd0;
    case (ph)
      P_BAD:  bo = 1'b1;
      P_EVAL: begin g = 1'b1; r = 1'b1; c = 1'b1; rs = irv[26:23]; b = 1'b1; end
      P_PCY:  begin po = 1'b1; y = 1'b1; b = 1'b1; end
      P_ADDR: begin
        co = 1'b1; a = 1'b1; z = 1'b1; b = 1'b1;
        v = int'(irv[18:0]);
        if (v >= 262144) v = v - 524288;
        sx = 32'(v);
      end
      P_WB:   begin zl = 1'b1; pc = 1'b1; b = 1'b1; end
      P_FIN:  begin d = 1'b1; t = tkv; b = 1'b1; end
      default: b = 1'b0;
    endcase
    return {g, r, c, rs, po, y, co, a, z, zl, pc, sx, b, d, t, bo};
  endfunction

  function automatic logic [31:0] mk_ir(input logic [4:0] op, input logic [3:0] rav,
                                        input logic [3:0] cond, input logic [18:0] imm);
    return {op, rav, cond, imm};
  endfunction

  task automatic check_out(input string tag, input logic [49:0] exp);
    logic [49:0] o, so;
    o  = {gra, rout, conin, ra, pcout, yin, cout, add, zin, zlo, pcin, cs, busy, done, tk, bad};
    so = {s_gra, s_rout, s_conin, s_ra, s_pcout, s_yin, s_cout, s_add, s_zin, s_zlo, s_pcin,
          s_cs, s_busy, s_done, s_tk, s_bad};
    checks++;
    assert ({o, so} === {exp, exp}) else begin
      errors++;
      $error("FAIL %s observed=%h/%h expected=%h", tag, o, so, exp);
    end
  endtask

  task automatic check_cnt(input string tag);
    logic [15:0] et, en;
    logic [1:0]  st, sn;
    et = 16'((m_t > 65535) ? 65535 : m_t);
    en = 16'((m_n > 65535) ? 65535 : m_n);
    st = 2'((m_t > 3) ? 3 : m_t);
    sn = 2'((m_n > 3) ? 3 : m_n);
    checks++;
    assert ({tcnt, ncnt, s_tcnt, s_ncnt} === {et, en, st, sn}) else begin
      errors++;
      $error("FAIL %s counters observed=%0d,%0d,%0d,%0d expected=%0d,%0d,%0d,%0d",
             tag, tcnt, ncnt, s_tcnt, s_ncnt, et, en, st, sn);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Called from an IDLE cycle: starts a branch and checks every cycle to FIN.
  task automatic do_branch(input string tag, input logic [31:0] irv, input logic conv,
                           input logic poke);
    start = 1'b1; ir = irv; con = 1'($urandom);
    step(); check_out({tag, ".eval"}, ev(P_EVAL, irv, 1'b0));
    start = poke; ir = $urandom; con = 1'($urandom);
    step(); check_out({tag, ".pcy"}, ev(P_PCY, irv, 1'b0));
    start = 1'b0; con = conv;
    step(); con = 1'($urandom);
    if (conv) begin
      check_out({tag, ".addr"}, ev(P_ADDR, irv, 1'b0));
      step(); check_out({tag, ".wb"}, ev(P_WB, irv, 1'b0));
      step(); check_out({tag, ".fin"}, ev(P_FIN, irv, 1'b1));
      m_t++;
    end else begin
      check_out({tag, ".fin"}, ev(P_FIN, irv, 1'b0));
      m_n++;
    end
  endtask

  task automatic idle_check(input string tag);
    start = 1'b0;
    step();
    check_out({tag, ".idle"}, ev(P_IDLE, 32'd0, 1'b0));
    check_cnt(tag);
  endtask

  initial begin
    logic [31:0] rv;
    logic c, p;
    clear = 1'b0; start = 1'b0; ir = 32'd0; con = 1'b0;
    #3;
    check_out("reset", ev(P_IDLE, 32'd0, 1'b0));
    check_cnt("reset");
    start = 1'b1; ir = mk_ir(BR, 4'd1, 4'd1, 19'd5);
    step();
    check_out("reset_hold", ev(P_IDLE, 32'd0, 1'b0));
    #1 clear = 1'b1;
    start = 1'b0;

    do_branch("taken", mk_ir(BR, 4'd3, 4'd1, 19'h00010), 1'b1, 1'b0);
    idle_check("taken");
    do_branch("ntaken", mk_ir(BR, 4'd9, 4'd1, 19'h00123), 1'b0, 1'b0);
    idle_check("ntaken");
    do_branch("negoff", mk_ir(BR, 4'd15, 4'd2, 19'h7FFFF), 1'b1, 1'b0);
    idle_check("negoff");

    start = 1'b1; ir = mk_ir(5'b00000, 4'd3, 4'd1, 19'h10);
    step(); check_out("badop", ev(P_BAD, 32'd0, 1'b0));
    start = 1'b0;
    step(); check_out("badop.after", ev(P_IDLE, 32'd0, 1'b0));

    do_branch("poke", mk_ir(BR, 4'd6, 4'd1, 19'h40000), 1'b1, 1'b1);
    idle_check("poke");
    idle_check("poke2");

    do_branch("b2b_a", mk_ir(BR, 4'd2, 4'd1, 19'h00001), 1'b0, 1'b0);
    idle_check("b2b_a");
    do_branch("b2b_b", mk_ir(BR, 4'd4, 4'd1, 19'h00002), 1'b1, 1'b0);
    idle_check("b2b_b");

    // Abort during ADDR.
    start = 1'b1; ir = mk_ir(BR, 4'd7, 4'd1, 19'h00020);
    step(); start = 1'b0;
    step(); con = 1'b1;
    step(); check_out("abort.addr", ev(P_ADDR, mk_ir(BR, 4'd7, 4'd1, 19'h00020), 1'b0));
    #2 clear = 1'b0;
    #1;
    m_t = 0; m_n = 0;
    check_out("abort.async", ev(P_IDLE, 32'd0, 1'b0));
    check_cnt("abort.async");
    step(); check_out("abort.held", ev(P_IDLE, 32'd0, 1'b0));
    #3 clear = 1'b1;
    do_branch("post_rst", mk_ir(BR, 4'd5, 4'd1, 19'h00008), 1'b1, 1'b0);
    idle_check("post_rst");

    for (int i = 0; i < 5; i++) begin
      do_branch("sat", mk_ir(BR, 4'(i), 4'd1, 19'(i * 3)), 1'b1, 1'b0);
      idle_check("sat");
    end

    for (int i = 0; i < 24; i++) begin
      rv = $urandom;
      c  = 1'($urandom);
      p  = 1'($urandom);
      if ($urandom_range(0, 4) == 0) begin
        if (rv[31:27] == BR) rv[31] = ~rv[31];
        start = 1'b1; ir = rv;
        step(); check_out("rnd.bad", ev(P_BAD, 32'd0, 1'b0));
        start = 1'b0;
        step(); check_out("rnd.bad.after", ev(P_IDLE, 32'd0, 1'b0));
      end else begin
        rv[31:27] = BR;
        do_branch("rnd", rv, c, p);
        idle_check("rnd");
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
